// File: rtl/router_port_rx.sv
// Serial-to-byte receiver for one router output port: reassembles LSB-first bits
// into bytes and queues them in a show-ahead FIFO with an end-of-packet flag.
module router_port_rx #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     dout,
  input  logic                     frameo_n,
  input  logic                     valido_n,
  output logic [7:0]               m_data,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_align,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  // Holds sr[7:1] only; sr[0] would be shifted out before it is ever used.
  logic [6:0]  r_sr;
  logic [2:0]  r_bitCnt;
  logic        r_errAlign;
  logic        r_ovf;
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic [8:0]  r_mem [DEPTH];

  logic        w_capture;
  logic        w_frameEnd;
  logic        w_byteDone;
  logic [2:0]  w_cntNext;
  logic [7:0]  w_byte;
  logic [AW:0] w_level;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;

  assign w_capture  = !valido_n && (r_state == ACTIVE || !frameo_n);
  assign w_frameEnd = (r_state == ACTIVE) && frameo_n;
  assign w_cntNext  = r_bitCnt + {2'b00, w_capture};
  assign w_byteDone = w_capture && (r_bitCnt == 3'd7);
  assign w_byte     = {dout, r_sr};

  assign w_level = r_wrPtr - r_rdPtr;
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (w_level == FULL_LEVEL);
  assign w_pop   = !w_empty && m_ready;
  assign w_push  = w_byteDone && (!w_full || w_pop);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (!frameo_n) w_stateNext = ACTIVE;
      ACTIVE:  if (frameo_n)  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_bitCnt   <= '0;
      r_errAlign <= 1'b0;
      r_ovf      <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_capture) r_sr <= w_byte[7:1];
      // A frame ending mid-byte throws away the partial byte and flags it.
      if (w_frameEnd) r_bitCnt <= '0;
      else            r_bitCnt <= w_cntNext;
      r_errAlign <= w_frameEnd && (w_cntNext != 3'd0);
      if (w_byteDone && !w_push) r_ovf <= 1'b1;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= {frameo_n, w_byte};
  end

  assign m_valid           = !w_empty;
  assign {m_last, m_data}  = m_valid ? r_mem[r_rdPtr[AW-1:0]] : 9'd0;
  assign level             = w_level;
  assign err_align         = r_errAlign;
  assign ovf               = r_ovf;

endmodule

// File: tb/tb_router_port_rx.sv
// Randomised scenario bench for router_port_rx: packets are modelled as bit lists
// and turned into expected FIFO entries, error pulses and overflow by plain arithmetic.
module tb_router_port_rx;

  localparam int DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       dout;
  logic       frameo_n;
  logic       valido_n;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic [$clog2(DEPTH):0] level;
  logic       err_align;
  logic       ovf;

  int testsRun    = 0;
  int testsFailed = 0;

  bit         pktBits[$];
  logic [8:0] gotQ[$];
  logic [8:0] expQ[$];
  int         errSeen     = 0;
  int         expErr      = 0;
  int         validCycles = 0;
  logic       expOvf      = 1'b0;
  bit         randReady   = 1'b0;

  router_port_rx #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .dout(dout), .frameo_n(frameo_n),
    .valido_n(valido_n), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .level(level), .err_align(err_align), .ovf(ovf)
  );

  always #5 clock = ~clock;

  // Observe handshakes and error pulses just before each rising edge.
  always begin
    @(negedge clock);
    #4;
    if (reset_n === 1'b1) begin
      if (m_valid && m_ready) gotQ.push_back({m_last, m_data});
      if (err_align) errSeen++;
      if (m_valid) validCycles++;
    end
  end

  task automatic tick();
    @(negedge clock);
    if (randReady) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idleCycle();
    tick();
    frameo_n = 1'b1;
    valido_n = 1'b1;
    dout     = 1'b0;
  endtask

  task automatic appendBits(input logic [7:0] v, input int n);
    for (int j = 0; j < n; j++) pktBits.push_back(v[j]);
  endtask

  task automatic clearScoreboard();
    gotQ.delete();
    expQ.delete();
    errSeen     = 0;
    expErr      = 0;
    validCycles = 0;
  endtask

  // Leaves the final bit on the wires; the caller supplies the following cycle.
  task automatic drivePacket(input int preIdle, input int gapA, input int gapB,
                             input int gapPct, input bit readyOnLast);
    int n;
    n = pktBits.size();
    for (int k = 0; k < preIdle; k++) begin
      tick();
      frameo_n = 1'b0;
      valido_n = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      if (i == gapA || i == gapB || (i > 0 && int'($urandom_range(0, 99)) < gapPct)) begin
        tick();
        frameo_n = 1'b0;
        valido_n = 1'b1;
        dout     = 1'($urandom_range(0, 1));
      end
      tick();
      frameo_n = (i == n - 1);
      valido_n = 1'b0;
      dout     = pktBits[i];
      if (readyOnLast && i == n - 1) m_ready = 1'b1;
    end
  endtask

  // Whole bytes of the packet go to the FIFO while it has room; a packet whose
  // length is not a multiple of eight ends with an alignment error.
  task automatic modelPacket(input int cap);
    int n;
    logic [7:0] b;
    n = pktBits.size();
    for (int k = 0; k < n / 8; k++) begin
      for (int j = 0; j < 8; j++) b[j] = pktBits[k * 8 + j];
      if (expQ.size() - gotQ.size() < cap)
        expQ.push_back({(n % 8 == 0) && (k == n / 8 - 1), b});
      else
        expOvf = 1'b1;
    end
    if (n % 8 != 0) expErr++;
  endtask

  task automatic doReset();
    reset_n  = 1'b0;
    frameo_n = 1'b1;
    valido_n = 1'b1;
    dout     = 1'b0;
    m_ready  = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b1;
    expOvf = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    tick();
    testsRun++;
    if (m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", m_valid); end
    testsRun++;
    if (level !== '0) begin testsFailed++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    testsRun++;
    if ({m_last, m_data} !== 9'd0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected 000", {m_last, m_data}); end
    testsRun++;
    if ({err_align, ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 00", {err_align, ovf}); end
  endtask

  task automatic test_single_byte();
    clearScoreboard();
    m_ready = 1'b1;
    pktBits.delete();
    appendBits(8'hA5, 8);
    drivePacket(0, -1, -1, 0, 1'b0);
    idleCycle();
    testsRun++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b1, 8'hA5})
      begin testsFailed++; $display("[TB] FAIL single_head: got v=%b l=%b d=%h expected v=1 l=1 d=a5", m_valid, m_last, m_data); end
    tick();
    modelPacket(DEPTH);
    testsRun++;
    if (m_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_drained: got %b expected 0", m_valid); end
    testsRun++;
    if (validCycles !== 1) begin testsFailed++; $display("[TB] FAIL single_valid_cycles: got %0d expected 1", validCycles); end
    testsRun++;
    if (errSeen !== expErr) begin testsFailed++; $display("[TB] FAIL single_err: got %0d expected %0d", errSeen, expErr); end
    testsRun++;
    if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL single_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL single_byte[%0d]: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
  endtask

  task automatic test_gaps_backpressure();
    int gA, gB;
    clearScoreboard();
    m_ready = 1'b0;
    pktBits.delete();
    appendBits(8'h01, 8);
    appendBits(8'h80, 8);
    appendBits(8'hFF, 8);
    gA = $urandom_range(1, 12);
    gB = gA + $urandom_range(1, 10);
    drivePacket(5, gA, gB, 0, 1'b0);
    idleCycle();
    modelPacket(DEPTH);
    testsRun++;
    if (level !== 5'd3) begin testsFailed++; $display("[TB] FAIL gaps_level_full: got %0d expected 3", level); end
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    testsRun++;
    if (level !== 5'd0) begin testsFailed++; $display("[TB] FAIL gaps_level_empty: got %0d expected 0", level); end
    testsRun++;
    if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL gaps_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL gaps_byte[%0d]: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
  endtask

  task automatic test_misaligned();
    clearScoreboard();
    m_ready = 1'b0;
    pktBits.delete();
    appendBits(8'h3C, 8);
    appendBits(8'($urandom_range(0, 7)), 3);
    drivePacket(0, -1, -1, 0, 1'b0);
    idleCycle();
    modelPacket(DEPTH);
    testsRun++;
    if (level !== 5'd1) begin testsFailed++; $display("[TB] FAIL misalign_level: got %0d expected 1", level); end
    tick();
    testsRun++;
    if (errSeen !== expErr) begin testsFailed++; $display("[TB] FAIL misalign_err: got %0d expected %0d", errSeen, expErr); end
    pktBits.delete();
    appendBits(8'h55, 8);
    drivePacket(0, -1, -1, 0, 1'b0);
    idleCycle();
    modelPacket(DEPTH);
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    testsRun++;
    if (errSeen !== expErr) begin testsFailed++; $display("[TB] FAIL misalign_err_after: got %0d expected %0d", errSeen, expErr); end
    testsRun++;
    if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL misalign_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL misalign_byte[%0d]: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
  endtask

  task automatic test_overflow();
    doReset();
    clearScoreboard();
    pktBits.delete();
    for (int v = 0; v < 18; v++) appendBits(8'(v), 8);
    drivePacket(0, -1, -1, 0, 1'b0);
    idleCycle();
    modelPacket(DEPTH);
    testsRun++;
    if (level !== 5'd16) begin testsFailed++; $display("[TB] FAIL ovf_level: got %0d expected 16", level); end
    testsRun++;
    if (ovf !== expOvf) begin testsFailed++; $display("[TB] FAIL ovf_flag: got %b expected %b", ovf, expOvf); end
    m_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    testsRun++;
    if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL ovf_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL ovf_byte[%0d]: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
    testsRun++;
    if (ovf !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_full_pop();
    doReset();
    clearScoreboard();
    pktBits.delete();
    for (int v = 0; v < DEPTH; v++) appendBits(8'($urandom_range(0, 255)), 8);
    drivePacket(0, -1, -1, 0, 1'b0);
    idleCycle();
    modelPacket(DEPTH);
    testsRun++;
    if (level !== 5'd16) begin testsFailed++; $display("[TB] FAIL fullpop_prefill: got %0d expected 16", level); end
    pktBits.delete();
    appendBits(8'hC3, 8);
    drivePacket(0, -1, -1, 0, 1'b1);
    idleCycle();
    m_ready = 1'b0;
    modelPacket(DEPTH);
    testsRun++;
    if (level !== 5'd16) begin testsFailed++; $display("[TB] FAIL fullpop_level: got %0d expected 16", level); end
    testsRun++;
    if (ovf !== expOvf) begin testsFailed++; $display("[TB] FAIL fullpop_ovf: got %b expected %b", ovf, expOvf); end
    m_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    testsRun++;
    if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL fullpop_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL fullpop_byte[%0d]: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    clearScoreboard();
    pktBits.delete();
    appendBits(8'h81, 8);
    appendBits(8'h7E, 8);
    drivePacket(0, -1, -1, 0, 1'b0);
    idleCycle();
    testsRun++;
    if (level !== 5'd2) begin testsFailed++; $display("[TB] FAIL rstmid_queued: got %0d expected 2", level); end
    for (int i = 0; i < 4; i++) begin
      tick();
      frameo_n = 1'b0;
      valido_n = 1'b0;
      dout     = 1'($urandom_range(0, 1));
    end
    tick();
    valido_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    testsRun++;
    if ({m_valid, m_last, m_data, level, err_align, ovf} !== '0)
      begin testsFailed++; $display("[TB] FAIL rstmid_outputs: got v=%b l=%b d=%h lvl=%0d e=%b o=%b expected all 0", m_valid, m_last, m_data, level, err_align, ovf); end
    tick();
    frameo_n = 1'b1;
    tick();
    #2 reset_n = 1'b1;
    expOvf = 1'b0;
    clearScoreboard();
    m_ready = 1'b1;
    pktBits.delete();
    appendBits(8'h5A, 8);
    drivePacket(0, -1, -1, 0, 1'b0);
    idleCycle();
    tick();
    modelPacket(DEPTH);
    tick();
    testsRun++;
    if (errSeen !== expErr) begin testsFailed++; $display("[TB] FAIL rstmid_err: got %0d expected %0d", errSeen, expErr); end
    testsRun++;
    if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL rstmid_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL rstmid_byte[%0d]: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
  endtask

  task automatic test_random();
    int len;
    clearScoreboard();
    randReady = 1'b1;
    for (int p = 0; p < 25; p++) begin
      pktBits.delete();
      len = $urandom_range(2, 40);
      for (int i = 0; i < len; i++) pktBits.push_back(1'($urandom_range(0, 1)));
      drivePacket($urandom_range(0, 2), -1, -1, 15, 1'b0);
      if ($urandom_range(0, 1) == 1) idleCycle();
      modelPacket(DEPTH);
    end
    idleCycle();
    randReady = 1'b0;
    m_ready   = 1'b1;
    for (int k = 0; k < 100 && level !== '0; k++) tick();
    tick();
    testsRun++;
    if (level !== '0) begin testsFailed++; $display("[TB] FAIL random_drain_timeout: got level %0d expected 0", level); end
    testsRun++;
    if (errSeen !== expErr) begin testsFailed++; $display("[TB] FAIL random_err: got %0d expected %0d", errSeen, expErr); end
    testsRun++;
    if (ovf !== expOvf) begin testsFailed++; $display("[TB] FAIL random_ovf: got %b expected %b", ovf, expOvf); end
    testsRun++;
    if (gotQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL random_count: got %0d expected %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      testsRun++;
      if (gotQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL random_byte[%0d]: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    frameo_n = 1'b1;
    valido_n = 1'b1;
    dout     = 1'b0;
    m_ready  = 1'b0;
    test_reset();
    test_single_byte();
    test_gaps_backpressure();
    test_misaligned();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
